trax_move_sequencer: RTL and testbench

Central turn controller for the Trax engine. It receives the opponent's move from the transceiver, then runs each board engine in order through start/done handshakes: apply-move, auto-complete (repeated until stable), commit-to-map, shift-down/shift-right and choose-move. It applies its own chosen move through the same chain and hands the result to the transceiver. It holds no board storage; it owns only ordering, move latching, iteration limits and error reporting.

---
 rtl/trax_move_sequencer_if.sv | 48 ++++
 rtl/trax_move_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_trax_move_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trax_move_sequencer_if.sv
// Handshake bundle between the Trax turn sequencer, the transceiver and the board engines.
// master = sequencer side, slave = transceiver/engine side.
interface trax_move_sequencer_if;
  logic        game_start;
  logic        color;
  logic        rx_valid;
  logic [21:0] rx_move;
  logic        upd_start;
  logic        upd_done;
  logic [21:0] upd_move;
  logic        ac_start;
  logic        ac_done;
  logic        ac_changed;
  logic        c2m_start;
  logic        c2m_done;
  logic        c2m_grow_top;
  logic        c2m_grow_left;
  logic        sd_start;
  logic        sd_done;
  logic        sr_start;
  logic        sr_done;
  logic        cm_start;
  logic        cm_done;
  logic [21:0] cm_move;
  logic [7:0]  cm_count;
  logic        tx_start;
  logic [21:0] tx_move;
  logic        busy;
  logic        overrun;
  logic [1:0]  err_code;
  logic [15:0] move_count;

  modport master (
    input  game_start, color, rx_valid, rx_move,
    input  upd_done, ac_done, ac_changed, c2m_done, c2m_grow_top, c2m_grow_left,
    input  sd_done, sr_done, cm_done, cm_move, cm_count,
    output upd_start, upd_move, ac_start, c2m_start, sd_start, sr_start, cm_start,
    output tx_start, tx_move, busy, overrun, err_code, move_count
  );

  modport slave (
    output game_start, color, rx_valid, rx_move,
    output upd_done, ac_done, ac_changed, c2m_done, c2m_grow_top, c2m_grow_left,
    output sd_done, sr_done, cm_done, cm_move, cm_count,
    input  upd_start, upd_move, ac_start, c2m_start, sd_start, sr_start, cm_start,
    input  tx_start, tx_move, busy, overrun, err_code, move_count
  );
endinterface

// File: rtl/trax_move_sequencer.sv
// Trax turn controller: runs the board engines for the opponent's move and then for our reply.
// Optional per-wait watchdog is enabled by defining TRAX_SEQ_WATCHDOG_EN.
module trax_move_sequencer #(
  parameter int unsigned MAX_AC_PASSES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  trax_move_sequencer_if.master bus_io
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_UPD    = 4'd1,
    S_AC     = 4'd2,
    S_C2M    = 4'd3,
    S_SHD    = 4'd4,
    S_SHR    = 4'd5,
    S_CHOOSE = 4'd6,
    S_TX     = 4'd7,
    S_ERR    = 4'd8
  } state_e;

  localparam int unsigned PASS_W       = $clog2(MAX_AC_PASSES + 1);
  localparam logic [21:0] OPENING_MOVE = 22'h100000;

  state_e              state_q, state_d;
  logic                phase_q, phase_d;
  logic [21:0]         cur_move_q, cur_move_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                grow_left_q, grow_left_d;
  logic                entry_q, entry_d;
  logic                upd_start_q, upd_start_d;
  logic                ac_start_q, ac_start_d;
  logic                c2m_start_q, c2m_start_d;
  logic                sd_start_q, sd_start_d;
  logic                sr_start_q, sr_start_d;
  logic                cm_start_q, cm_start_d;
  logic                tx_start_q, tx_start_d;
  logic [21:0]         tx_move_q, tx_move_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [15:0]         move_count_q, move_count_d;
  logic                enter_s;
  logic                wait_s;
`ifdef TRAX_SEQ_WATCHDOG_EN
  logic [15:0]         wd_q, wd_d;
  logic                engine_wait_s;
`endif

  // After commit/shift, the opponent chain continues to CHOOSE and our own chain finishes in TX.
  function automatic state_e next_after_commit(input logic phase);
    next_after_commit = phase ? S_TX : S_CHOOSE;
  endfunction

  // Next-state, start-pulse and status computation.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cur_move_d   = cur_move_q;
    pass_d       = pass_q;
    grow_left_d  = grow_left_q;
    err_code_d   = err_code_q;
    tx_move_d    = tx_move_q;
    move_count_d = move_count_q;
    enter_s      = 1'b0;
    // The start cycle of a state never accepts done, so a same-cycle done is dropped.
    wait_s       = ~entry_q;
    overrun_d    = overrun_q | (busy_q & (bus_io.rx_valid | bus_io.game_start));

    case (state_q)
      S_IDLE: begin
        if (bus_io.game_start) begin
          if (!bus_io.color) begin
            cur_move_d = OPENING_MOVE;
            phase_d    = 1'b1;
            state_d    = S_UPD;
            enter_s    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (bus_io.rx_valid) begin
          cur_move_d = bus_io.rx_move;
          phase_d    = 1'b0;
          state_d    = S_UPD;
          enter_s    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UPD: begin
        if (wait_s && bus_io.upd_done) begin
          pass_d  = PASS_W'(1);
          state_d = S_AC;
          enter_s = 1'b1;
        end else begin
          state_d = S_UPD;
        end
      end
      S_AC: begin
        if (wait_s && bus_io.ac_done) begin
          enter_s = 1'b1;
          if (!bus_io.ac_changed) begin
            state_d = S_C2M;
          end else if (pass_q < PASS_W'(MAX_AC_PASSES)) begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = S_AC;
          end else begin
            err_code_d = 2'b01;
            state_d    = S_ERR;
          end
        end else begin
          state_d = S_AC;
        end
      end
      S_C2M: begin
        if (wait_s && bus_io.c2m_done) begin
          grow_left_d = bus_io.c2m_grow_left;
          enter_s     = 1'b1;
          if (bus_io.c2m_grow_top) begin
            state_d = S_SHD;
          end else if (bus_io.c2m_grow_left) begin
            state_d = S_SHR;
          end else begin
            state_d = next_after_commit(phase_q);
          end
        end else begin
          state_d = S_C2M;
        end
      end
      S_SHD: begin
        if (wait_s && bus_io.sd_done) begin
          enter_s = 1'b1;
          state_d = grow_left_q ? S_SHR : next_after_commit(phase_q);
        end else begin
          state_d = S_SHD;
        end
      end
      S_SHR: begin
        if (wait_s && bus_io.sr_done) begin
          enter_s = 1'b1;
          state_d = next_after_commit(phase_q);
        end else begin
          state_d = S_SHR;
        end
      end
      S_CHOOSE: begin
        if (wait_s && bus_io.cm_done) begin
          enter_s = 1'b1;
          if (bus_io.cm_count == 8'd0) begin
            err_code_d = 2'b10;
            state_d    = S_ERR;
          end else begin
            cur_move_d = bus_io.cm_move;
            phase_d    = 1'b1;
            state_d    = S_UPD;
          end
        end else begin
          state_d = S_CHOOSE;
        end
      end
      S_TX: begin
        state_d = S_IDLE;
        enter_s = 1'b1;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
        enter_s = 1'b1;
      end
    endcase

`ifdef TRAX_SEQ_WATCHDOG_EN
    engine_wait_s = (state_q == S_UPD) | (state_q == S_AC) | (state_q == S_C2M) |
                    (state_q == S_SHD) | (state_q == S_SHR) | (state_q == S_CHOOSE);
    if (!enter_s && engine_wait_s) begin
      if (({1'b0, wd_q} + 17'd1) >= 17'(TIMEOUT_CYCLES)) begin
        wd_d       = 16'd0;
        err_code_d = 2'b11;
        state_d    = S_ERR;
        enter_s    = 1'b1;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end else begin
      wd_d = 16'd0;
    end
`endif

    upd_start_d = enter_s & (state_d == S_UPD);
    ac_start_d  = enter_s & (state_d == S_AC);
    c2m_start_d = enter_s & (state_d == S_C2M);
    sd_start_d  = enter_s & (state_d == S_SHD);
    sr_start_d  = enter_s & (state_d == S_SHR);
    cm_start_d  = enter_s & (state_d == S_CHOOSE);
    tx_start_d  = enter_s & (state_d == S_TX);
    entry_d     = enter_s;
    busy_d      = (state_d != S_IDLE) & (state_d != S_ERR);

    if (enter_s && (state_d == S_TX)) begin
      tx_move_d    = cur_move_q;
      move_count_d = move_count_q + 16'd1;
    end else begin
      tx_move_d    = tx_move_q;
      move_count_d = move_count_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      cur_move_q   <= 22'd0;
      pass_q       <= '0;
      grow_left_q  <= 1'b0;
      entry_q      <= 1'b0;
      upd_start_q  <= 1'b0;
      ac_start_q   <= 1'b0;
      c2m_start_q  <= 1'b0;
      sd_start_q   <= 1'b0;
      sr_start_q   <= 1'b0;
      cm_start_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_move_q    <= 22'd0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      err_code_q   <= 2'b00;
      move_count_q <= 16'd0;
`ifdef TRAX_SEQ_WATCHDOG_EN
      wd_q         <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cur_move_q   <= cur_move_d;
      pass_q       <= pass_d;
      grow_left_q  <= grow_left_d;
      entry_q      <= entry_d;
      upd_start_q  <= upd_start_d;
      ac_start_q   <= ac_start_d;
      c2m_start_q  <= c2m_start_d;
      sd_start_q   <= sd_start_d;
      sr_start_q   <= sr_start_d;
      cm_start_q   <= cm_start_d;
      tx_start_q   <= tx_start_d;
      tx_move_q    <= tx_move_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      err_code_q   <= err_code_d;
      move_count_q <= move_count_d;
`ifdef TRAX_SEQ_WATCHDOG_EN
      wd_q         <= wd_d;
`endif
    end
  end

  // cur_move only changes on entry to UPD, so it is stable for the whole apply-move handshake.
  assign bus_io.upd_move   = cur_move_q;
  assign bus_io.upd_start  = upd_start_q;
  assign bus_io.ac_start   = ac_start_q;
  assign bus_io.c2m_start  = c2m_start_q;
  assign bus_io.sd_start   = sd_start_q;
  assign bus_io.sr_start   = sr_start_q;
  assign bus_io.cm_start   = cm_start_q;
  assign bus_io.tx_start   = tx_start_q;
  assign bus_io.tx_move    = tx_move_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.overrun    = overrun_q;
  assign bus_io.err_code   = err_code_q;
  assign bus_io.move_count = move_count_q;

endmodule

// File: tb/tb_trax_move_sequencer.sv
// Scoreboard bench for trax_move_sequencer: expected start/tx pulses are queued when stimulus is
// driven and popped as the DUT emits them; engines are modelled as zero-wait responders.
module tb_trax_move_sequencer;

  localparam int K_UPD = 0, K_AC = 1, K_C2M = 2, K_SD = 3, K_SR = 4, K_CM = 5, K_TX = 6, K_NONE = 7;

  typedef struct {
    int          kind;
    int          cyc;
    logic [21:0] move;
  } ev_t;

  logic clk_s = 1'b0;
  logic rst_n_s;

  trax_move_sequencer_if bus();

`ifdef TRAX_SEQ_WATCHDOG_EN
  trax_move_sequencer #(.MAX_AC_PASSES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk_s), .rst_n(rst_n_s), .bus_io(bus));
`else
  trax_move_sequencer #(.MAX_AC_PASSES(8)) dut (
    .clk(clk_s), .rst_n(rst_n_s), .bus_io(bus));
`endif

  always #5 clk_s = ~clk_s;

  ev_t         ev_q[$];
  int          cyc = 0;
  int          t0;
  int          tn;
  int          total_cnt = 0;
  int          bad_cnt = 0;
  logic        upd_en = 1'b1;
  int          ac_chg_n = 0;
  logic        gt_once = 1'b0;
  logic        gl_once = 1'b0;
  logic [21:0] cm_move_cfg = 22'h300802;
  logic [7:0]  cm_count_cfg = 8'd5;
  logic        upd_pend = 1'b0, ac_pend = 1'b0, c2m_pend = 1'b0;
  logic        sd_pend = 1'b0, sr_pend = 1'b0, cm_pend = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    total_cnt++;
    if (obs != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int k, input int c, input logic [21:0] m);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.move = m;
    ev_q.push_back(e);
  endtask

  // One apply chain: UPD, acp AC passes, C2M, optional shifts; tn is where the next pulse lands.
  task automatic push_chain(input int t, input logic [21:0] m, input int acp,
                            input bit sd, input bit sr, output int tn_o);
    int c;
    c = t;
    push_ev(K_UPD, c, m);
    c += 2;
    for (int i = 0; i < acp; i++) begin
      push_ev(K_AC, c, 22'd0);
      c += 2;
    end
    push_ev(K_C2M, c, 22'd0);
    c += 2;
    if (sd) begin
      push_ev(K_SD, c, 22'd0);
      c += 2;
    end
    if (sr) begin
      push_ev(K_SR, c, 22'd0);
      c += 2;
    end
    tn_o = c;
  endtask

  task automatic log_pulse(input int k, input logic [21:0] m);
    ev_t e;
    if (ev_q.size() == 0) begin
      check_val("extra_pulse", k, K_NONE);
    end else begin
      e = ev_q.pop_front();
      check_val("pulse_kind", k, e.kind);
      check_val("pulse_cycle", cyc, e.cyc);
      if (k == K_UPD || k == K_TX) check_val("pulse_move", m, e.move);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_s);
      #1;
    end
  endtask

  task automatic drive_in(input logic [21:0] m, input logic gs, input logic col, input logic rx);
    bus.rx_move    = m;
    bus.game_start = gs;
    bus.color      = col;
    bus.rx_valid   = rx;
    t0             = cyc;
  endtask

  task automatic clear_in();
    bus.game_start = 1'b0;
    bus.rx_valid   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      step(1);
      n++;
    end
    check_val("idle_wait", bus.busy, 0);
  endtask

  task automatic do_reset();
    rst_n_s = 1'b0;
    step(2);
    rst_n_s = 1'b1;
    step(1);
  endtask

  // Monitor plus zero-wait engine models: done follows one cycle after each start.
  initial begin
    forever begin
      @(posedge clk_s);
      cyc++;
      #1;
      if (bus.upd_start) log_pulse(K_UPD, bus.upd_move);
      if (bus.ac_start)  log_pulse(K_AC, 22'd0);
      if (bus.c2m_start) log_pulse(K_C2M, 22'd0);
      if (bus.sd_start)  log_pulse(K_SD, 22'd0);
      if (bus.sr_start)  log_pulse(K_SR, 22'd0);
      if (bus.cm_start)  log_pulse(K_CM, 22'd0);
      if (bus.tx_start)  log_pulse(K_TX, bus.tx_move);
      bus.upd_done = upd_pend & upd_en;
      bus.ac_done  = ac_pend;
      if (ac_pend && ac_chg_n > 0) begin
        bus.ac_changed = 1'b1;
        ac_chg_n--;
      end else begin
        bus.ac_changed = 1'b0;
      end
      bus.c2m_done      = c2m_pend;
      bus.c2m_grow_top  = c2m_pend & gt_once;
      bus.c2m_grow_left = c2m_pend & gl_once;
      if (c2m_pend) begin
        gt_once = 1'b0;
        gl_once = 1'b0;
      end
      bus.sd_done  = sd_pend;
      bus.sr_done  = sr_pend;
      bus.cm_done  = cm_pend;
      bus.cm_move  = cm_move_cfg;
      bus.cm_count = cm_count_cfg;
      upd_pend = bus.upd_start;
      ac_pend  = bus.ac_start;
      c2m_pend = bus.c2m_start;
      sd_pend  = bus.sd_start;
      sr_pend  = bus.sr_start;
      cm_pend  = bus.cm_start;
    end
  end

  initial begin
    rst_n_s = 1'b0;
    bus.game_start = 1'b0; bus.color = 1'b0; bus.rx_valid = 1'b0; bus.rx_move = 22'd0;
    bus.upd_done = 1'b0; bus.ac_done = 1'b0; bus.ac_changed = 1'b0;
    bus.c2m_done = 1'b0; bus.c2m_grow_top = 1'b0; bus.c2m_grow_left = 1'b0;
    bus.sd_done = 1'b0; bus.sr_done = 1'b0; bus.cm_done = 1'b0;
    bus.cm_move = 22'd0; bus.cm_count = 8'd0;
    step(3);
    rst_n_s = 1'b1;
    step(1);

    check_val("rst_busy", bus.busy, 0);
    check_val("rst_err", bus.err_code, 0);
    check_val("rst_overrun", bus.overrun, 0);
    check_val("rst_count", bus.move_count, 0);
    check_val("rst_tx_move", bus.tx_move, 0);
    check_val("rst_upd_move", bus.upd_move, 0);

    // White opening; a simultaneous rx_valid must lose to game_start.
    drive_in(22'h3FFFFF, 1'b1, 1'b0, 1'b1);
    push_chain(t0 + 1, 22'h100000, 1, 1'b0, 1'b0, tn);
    push_ev(K_TX, tn, 22'h100000);
    step(1);
    clear_in();
    wait_idle(100);
    check_val("open_sb", ev_q.size(), 0);
    check_val("open_count", bus.move_count, 1);
    check_val("open_tx_move", bus.tx_move, 22'h100000);

    // Black: game_start alone starts nothing.
    drive_in(22'd0, 1'b1, 1'b1, 1'b0);
    step(1);
    clear_in();
    step(6);
    check_val("black_busy", bus.busy, 0);

    // Opponent move, no shifts, one AC pass per chain.
    drive_in(22'h200401, 1'b0, 1'b0, 1'b1);
    push_chain(t0 + 1, 22'h200401, 1, 1'b0, 1'b0, tn);
    push_ev(K_CM, tn, 22'd0);
    push_chain(tn + 2, 22'h300802, 1, 1'b0, 1'b0, tn);
    push_ev(K_TX, tn, 22'h300802);
    check_val("opp_tx_cycle", tn - t0, 15);
    step(1);
    clear_in();
    wait_idle(100);
    check_val("opp_sb", ev_q.size(), 0);
    check_val("opp_count", bus.move_count, 2);

    // Both grow flags on the first commit: SHD then SHR.
    gt_once = 1'b1;
    gl_once = 1'b1;
    cm_move_cfg = 22'h1_00C03;
    drive_in(22'h0_00802, 1'b0, 1'b0, 1'b1);
    push_chain(t0 + 1, 22'h0_00802, 1, 1'b1, 1'b1, tn);
    push_ev(K_CM, tn, 22'd0);
    push_chain(tn + 2, 22'h1_00C03, 1, 1'b0, 1'b0, tn);
    push_ev(K_TX, tn, 22'h1_00C03);
    step(1);
    clear_in();
    wait_idle(100);
    check_val("grow_sb", ev_q.size(), 0);
    check_val("grow_count", bus.move_count, 3);

    // Exactly MAX_AC_PASSES passes (last one stable) still converges.
    ac_chg_n = 7;
    cm_move_cfg = 22'h2_01405;
    drive_in(22'h3_00404, 1'b0, 1'b0, 1'b1);
    push_chain(t0 + 1, 22'h3_00404, 8, 1'b0, 1'b0, tn);
    push_ev(K_CM, tn, 22'd0);
    push_chain(tn + 2, 22'h2_01405, 1, 1'b0, 1'b0, tn);
    push_ev(K_TX, tn, 22'h2_01405);
    step(1);
    clear_in();
    wait_idle(200);
    check_val("ac8_sb", ev_q.size(), 0);
    check_val("ac8_err", bus.err_code, 0);
    check_val("ac8_count", bus.move_count, 4);

    // rx_valid while busy: overrun set, chain untouched.
    check_val("ovr_before", bus.overrun, 0);
    cm_move_cfg = 22'h300802;
    drive_in(22'h200401, 1'b0, 1'b0, 1'b1);
    push_chain(t0 + 1, 22'h200401, 1, 1'b0, 1'b0, tn);
    push_ev(K_CM, tn, 22'd0);
    push_chain(tn + 2, 22'h300802, 1, 1'b0, 1'b0, tn);
    push_ev(K_TX, tn, 22'h300802);
    step(1);
    clear_in();
    step(1);
    bus.rx_move  = 22'h1_0FFFF;
    bus.rx_valid = 1'b1;
    step(1);
    clear_in();
    wait_idle(100);
    check_val("ovr_sb", ev_q.size(), 0);
    check_val("ovr_flag", bus.overrun, 1);
    check_val("ovr_count", bus.move_count, 5);

    // No legal move.
    cm_count_cfg = 8'd0;
    drive_in(22'h200401, 1'b0, 1'b0, 1'b1);
    push_chain(t0 + 1, 22'h200401, 1, 1'b0, 1'b0, tn);
    push_ev(K_CM, tn, 22'd0);
    step(1);
    clear_in();
    wait_idle(100);
    check_val("nolegal_sb", ev_q.size(), 0);
    check_val("nolegal_err", bus.err_code, 2);
    check_val("nolegal_count", bus.move_count, 5);
    do_reset();
    cm_count_cfg = 8'd5;
    check_val("rst2_err", bus.err_code, 0);
    check_val("rst2_overrun", bus.overrun, 0);

    // Auto-complete never converges: 8 passes, then error; later rx ignored.
    ac_chg_n = 1000;
    drive_in(22'h200401, 1'b0, 1'b0, 1'b1);
    push_ev(K_UPD, t0 + 1, 22'h200401);
    for (int i = 0; i < 8; i++) push_ev(K_AC, t0 + 3 + 2 * i, 22'd0);
    step(1);
    clear_in();
    wait_idle(100);
    check_val("acfail_sb", ev_q.size(), 0);
    check_val("acfail_err", bus.err_code, 1);
    drive_in(22'h200401, 1'b0, 1'b0, 1'b1);
    step(1);
    clear_in();
    step(20);
    check_val("err_hold", bus.err_code, 1);
    check_val("err_busy", bus.busy, 0);
    check_val("err_overrun", bus.overrun, 0);
    do_reset();
    ac_chg_n = 0;

    // Reset mid-chain aborts everything after the reset edge.
    drive_in(22'h200401, 1'b0, 1'b0, 1'b1);
    push_ev(K_UPD, t0 + 1, 22'h200401);
    push_ev(K_AC, t0 + 3, 22'd0);
    step(1);
    clear_in();
    step(3);
    rst_n_s = 1'b0;
    step(2);
    rst_n_s = 1'b1;
    step(20);
    check_val("abort_sb", ev_q.size(), 0);
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_count", bus.move_count, 0);

    // Apply-move engine never answers.
    upd_en = 1'b0;
    drive_in(22'h200401, 1'b0, 1'b0, 1'b1);
    push_ev(K_UPD, t0 + 1, 22'h200401);
    step(1);
    clear_in();
`ifdef TRAX_SEQ_WATCHDOG_EN
    step(15);
    check_val("wd_early", bus.err_code, 0);
    step(1);
    check_val("wd_code", bus.err_code, 3);
    check_val("wd_busy", bus.busy, 0);
`else
    step(1000);
    check_val("hang_busy", bus.busy, 1);
    check_val("hang_err", bus.err_code, 0);
`endif
    check_val("final_sb", ev_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
